scratchpad_ctrl: RTL and testbench
==================================

// Module: scratchpad_ctrl
// PURPOSE
//  Parametrised control hub for an N-bank scratchpad; generalises the fixed 4-bank top-level glue.
//  Buffers issued instructions and broadcasts each one to NUM_BANKS bank-access FSMs.
//  Retires an instruction only once every bank has acked it.
//  Round-robin arbitrates bank DRAM load requests; buffers systolic-array psum output with backpressure.
// PARAMETERS
//  NUM_BANKS    4   bank-access FSM count (>=2)
//  INSTR_W      40  instruction word width; opcode = [INSTR_W-1:INSTR_W-2]
//  INSTR_DEPTH  4   instruction FIFO entries (power of 2)
//  PSUM_DEPTH   8   psum-out FIFO entries (power of 2)
//  ADDR_W       32  DRAM address width
//  PSUM_W       64  psum row data width
//  ROW_W        2   psum row-select width
//  MAT_W        6   gemm matrix-select width; field = [MAT_W-1:0]; new_weight bit = [INSTR_W-3]
// PORTS
//  CLK             in   1                  clock, rising edge
//  nRST            in   1                  async active-low reset
//  instr_wen       in   1                  push instruction
//  instr_wdata     in   INSTR_W            instruction
//  instr_full      out  1                  instruction FIFO full
//  instr_valid     out  1                  head instruction presented to banks
//  instr_head      out  INSTR_W            head instruction
//  instr_new       out  1                  1-cycle pulse, first cycle of each new head
//  bank_done       in   NUM_BANKS          per-bank ack of head (pulse)
//  gemm_mat        out  MAT_W              latched matrix select of last GEMM (opcode 2'd3)
//  new_weight      out  1                  pulse: instr_new & opcode==3 & new_weight bit
//  load_req        in   NUM_BANKS          per-bank DRAM load request (level)
//  load_addr_in    in   NUM_BANKS*ADDR_W   per-bank address, bank i at [i*ADDR_W +: ADDR_W]
//  load_ack        out  NUM_BANKS          1-cycle one-hot ack to granted bank
//  sLoad           out  1                  DRAM load strobe
//  load_addr       out  ADDR_W             DRAM load address
//  sLoad_hit       in   1                  DRAM load complete
//  psumout_en      in   1                  psum row write
//  psumout_row     in   ROW_W              row select
//  psumout_data    in   PSUM_W             row data
//  psumout_ready   out  1                  = !psum FIFO full
//  psum_ren        in   NUM_BANKS          per-bank pop request (ORed)
//  psum_empty      out  1                  psum FIFO empty
//  psum_rdata      out  ROW_W+PSUM_W       {row, data} at head
//  err_overflow    out  2                  sticky {psum drop, instr drop}
//  stat_retired    out  16                 retired-instruction count (see CONFIGURATION)
//  stat_load_busy  out  16                 cycles sLoad high (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): FIFOs empty, done mask 0, gemm_mat 0, arbiter IDLE, rr pointer = NUM_BANKS-1,
//   err 0, stats 0. All outputs 0, except psumout_ready=1 and psum_empty=1.
//  Instr FIFO: push on instr_wen & !instr_full; push while full is dropped and sets err_overflow[0].
//   instr_valid = !empty; instr_new pulses the cycle after a head first appears (push-to-empty or pop with next entry).
//  Retire: mask |= bank_done while instr_valid. Pop when (mask|bank_done) == all ones; mask clears that edge.
//   Next head is visible the following cycle. Simultaneous push+pop is legal when full.
//  gemm_mat <= head[MAT_W-1:0] on the instr_new cycle when opcode==3; otherwise it holds.
//  Load FSM IDLE->BUSY: when any load_req, grant the first requester after the rr pointer.
//   Latch owner and address; sLoad=1 from the next cycle.
//  BUSY: sLoad and load_addr held; on sLoad_hit, load_ack[owner]=1 for 1 cycle, rr <= owner, ->IDLE.
//  Requester drops load_req the cycle after its ack. Latency from req to sLoad is 1 cycle; back-to-back grants have 1 IDLE cycle.
//  Psum FIFO: write on psumout_en & psumout_ready; en while full is dropped and sets err_overflow[1].
//   Read on |psum_ren & !empty; a read while empty is ignored. Write is blocked when full, even with a simultaneous read.
//  Pointers wrap modulo depth; count is depth+1 wide.
// CONFIGURATION
//  SCRATCHPAD_CTRL_STATS_EN defined: stat_retired +1 per pop; stat_load_busy +1 per sLoad cycle. Both saturate at 16'hFFFF.
//  SCRATCHPAD_CTRL_STATS_EN undefined: no stat counters are built; both ports tied to 0.
// STRUCTURE
//  types_pkg: opcode enum (GEMM = 2'd3), instruction field offsets, psumoutFIFO_t {row_s, data}.
//  Sub-module rr_arbiter #(N): one-hot grant from req and last-grant pointer. FIFOs use socetlib_fifo.
// TESTING
//  1. Push 1 GEMM (opcode 3, new_weight 1, sel 6'd5) -> next cycle instr_new=1, new_weight=1; following cycle gemm_mat=5.
//  2. bank_done 0001,0010,0100 then 1000 on later cycles -> pop only on 1000 cycle; all 4'b1111 in one cycle -> pop that cycle.
//  3. load_req=4'b1010 held, addr1=0x100, addr3=0x300 -> bank1 served first (0x100), then bank3; then req 4'b0010 -> bank1.
//  4. 9 psum writes, no reads -> psumout_ready=0 after 8, 9th dropped, err_overflow[1]=1; 8 pops return entries in order.
//  5. Assert nRST mid-BUSY with FIFOs partly full -> sLoad=0, instr_valid=0, psum_empty=1 immediately.
//  6. 5 pushes with no retire -> instr_full after 4, err_overflow[0]=1; with the STATS macro, 4 retires -> stat_retired=4.

Source files
------------

// File: rtl/scratchpad_ctrl_pkg.sv
// Shared opcode encoding, instruction field layout and psum FIFO entry type
// for the scratchpad control hub.
package scratchpad_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_RSVD0 = 2'd0,
    OP_RSVD1 = 2'd1,
    OP_RSVD2 = 2'd2,
    OP_GEMM  = 2'd3
  } opcode_e;

  // Field positions counted down from the instruction MSB.
  localparam int OPCODE_W       = 2;
  localparam int NEW_WEIGHT_OFS = 3;

  typedef enum logic {
    LOAD_IDLE = 1'b0,
    LOAD_BUSY = 1'b1
  } load_state_e;

  // Layout of one psum FIFO entry at the default widths: {row, data}.
  typedef struct packed {
    logic [1:0]  row_s;
    logic [63:0] data;
  } psumoutFIFO_t;

  function automatic logic is_gemm(input logic [OPCODE_W-1:0] opc);
    return opc == OP_GEMM;
  endfunction

endpackage

// File: rtl/scratchpad_ctrl_if.sv
// Bus bundle between the scratchpad controller (slave) and its environment
// (master): instruction, bank-ack, DRAM-load, psum and status signals.
interface scratchpad_ctrl_if #(
  parameter int NUM_BANKS = 4,
  parameter int INSTR_W   = 40,
  parameter int ADDR_W    = 32,
  parameter int PSUM_W    = 64,
  parameter int ROW_W     = 2,
  parameter int MAT_W     = 6
);
  logic                          instr_wen;
  logic [INSTR_W-1:0]            instr_wdata;
  logic                          instr_full;
  logic                          instr_valid;
  logic [INSTR_W-1:0]            instr_head;
  logic                          instr_new;
  logic [NUM_BANKS-1:0]          bank_done;
  logic [MAT_W-1:0]              gemm_mat;
  logic                          new_weight;
  logic [NUM_BANKS-1:0]          load_req;
  logic [NUM_BANKS*ADDR_W-1:0]   load_addr_in;
  logic [NUM_BANKS-1:0]          load_ack;
  logic                          sLoad;
  logic [ADDR_W-1:0]             load_addr;
  logic                          sLoad_hit;
  logic                          psumout_en;
  logic [ROW_W-1:0]              psumout_row;
  logic [PSUM_W-1:0]             psumout_data;
  logic                          psumout_ready;
  logic [NUM_BANKS-1:0]          psum_ren;
  logic                          psum_empty;
  logic [ROW_W+PSUM_W-1:0]       psum_rdata;
  logic [1:0]                    err_overflow;
  logic [15:0]                   stat_retired;
  logic [15:0]                   stat_load_busy;

  modport master (
    output instr_wen, instr_wdata, bank_done, load_req, load_addr_in, sLoad_hit,
           psumout_en, psumout_row, psumout_data, psum_ren,
    input  instr_full, instr_valid, instr_head, instr_new, gemm_mat, new_weight,
           load_ack, sLoad, load_addr, psumout_ready, psum_empty, psum_rdata,
           err_overflow, stat_retired, stat_load_busy
  );

  modport slave (
    input  instr_wen, instr_wdata, bank_done, load_req, load_addr_in, sLoad_hit,
           psumout_en, psumout_row, psumout_data, psum_ren,
    output instr_full, instr_valid, instr_head, instr_new, gemm_mat, new_weight,
           load_ack, sLoad, load_addr, psumout_ready, psum_empty, psum_rdata,
           err_overflow, stat_retired, stat_load_busy
  );
endinterface

// File: rtl/scratchpad_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester strictly after
// the last-granted index, wrapping around.
module scratchpad_ctrl_rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt
);
  logic [N-1:0] hi_mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = (IDX_W'(gi) > last);
  end

  // Prefer requesters above the pointer; fall back to the lowest index overall.
  assign req_hi = req & hi_mask;
  assign pick   = (|req_hi) ? req_hi : req;
  assign gnt    = pick & (-pick);
endmodule

// File: rtl/scratchpad_ctrl.sv
// Scratchpad control hub: instruction broadcast/retire, round-robin DRAM load
// arbitration and psum output buffering. Optional stats: SCRATCHPAD_CTRL_STATS_EN.
module scratchpad_ctrl
  import scratchpad_ctrl_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int INSTR_W     = 40,
  parameter int INSTR_DEPTH = 4,
  parameter int PSUM_DEPTH  = 8,
  parameter int ADDR_W      = 32,
  parameter int PSUM_W      = 64,
  parameter int ROW_W       = 2,
  parameter int MAT_W       = 6
) (
  input logic              CLK,
  input logic              nRST,
  scratchpad_ctrl_if.slave bus
);
  localparam int IPTR_W = $clog2(INSTR_DEPTH);
  localparam int PPTR_W = $clog2(PSUM_DEPTH);
  localparam int IDX_W  = $clog2(NUM_BANKS);
  localparam int PD_W   = ROW_W + PSUM_W;

  // ---------------- instruction FIFO and retire ----------------
  logic [INSTR_W-1:0]   instr_mem [INSTR_DEPTH];
  logic [IPTR_W-1:0]    iw_ptr_reg, ir_ptr_reg;
  logic [IPTR_W:0]      icount_reg, icount_next;
  logic [NUM_BANKS-1:0] mask_reg;
  logic                 instr_new_reg, instr_new_next;
  logic [MAT_W-1:0]     gemm_mat_reg;
  logic                 instr_empty, instr_full_w, instr_push, instr_pop, instr_drop;
  logic [INSTR_W-1:0]   head;
  logic                 head_gemm;

  assign instr_empty    = (icount_reg == '0);
  assign instr_full_w   = (icount_reg == (IPTR_W+1)'(INSTR_DEPTH));
  assign head           = instr_empty ? '0 : instr_mem[ir_ptr_reg];
  assign head_gemm      = is_gemm(head[INSTR_W-1 -: OPCODE_W]);
  assign instr_pop      = !instr_empty && ((mask_reg | bus.bank_done) == '1);
  assign instr_push     = bus.instr_wen && (!instr_full_w || instr_pop);
  assign instr_drop     = bus.instr_wen && !instr_push;
  assign icount_next    = icount_reg + (IPTR_W+1)'(instr_push) - (IPTR_W+1)'(instr_pop);
  // A fresh head shows up after a push into an empty FIFO or a pop that leaves entries.
  assign instr_new_next = (icount_next != '0) && (instr_empty || instr_pop);

  always_ff @(posedge CLK) begin
    if (instr_push) instr_mem[iw_ptr_reg] <= bus.instr_wdata;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iw_ptr_reg    <= '0;
      ir_ptr_reg    <= '0;
      icount_reg    <= '0;
      mask_reg      <= '0;
      instr_new_reg <= 1'b0;
      gemm_mat_reg  <= '0;
    end else begin
      if (instr_push) iw_ptr_reg <= iw_ptr_reg + IPTR_W'(1);
      if (instr_pop)  ir_ptr_reg <= ir_ptr_reg + IPTR_W'(1);
      icount_reg    <= icount_next;
      instr_new_reg <= instr_new_next;
      if (instr_pop)         mask_reg <= '0;
      else if (!instr_empty) mask_reg <= mask_reg | bus.bank_done;
      if (instr_new_reg && head_gemm) gemm_mat_reg <= head[MAT_W-1:0];
    end
  end

  assign bus.instr_full  = instr_full_w;
  assign bus.instr_valid = !instr_empty;
  assign bus.instr_head  = head;
  assign bus.instr_new   = instr_new_reg;
  assign bus.gemm_mat    = gemm_mat_reg;
  assign bus.new_weight  = instr_new_reg && head_gemm && head[INSTR_W-NEW_WEIGHT_OFS];

  // ---------------- DRAM load arbitration ----------------
  load_state_e          state_reg, state_next;
  logic [IDX_W-1:0]     owner_reg, owner_next, rr_reg, rr_next, gnt_idx;
  logic [ADDR_W-1:0]    addr_reg, addr_next;
  logic [NUM_BANKS-1:0] gnt, ack;

  scratchpad_ctrl_rr_arbiter #(.N(NUM_BANKS)) u_arb (
    .req  (bus.load_req),
    .last (rr_reg),
    .gnt  (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (gnt[i]) gnt_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;
    addr_next  = addr_reg;
    ack        = '0;
    case (state_reg)
      LOAD_IDLE: begin
        if (|bus.load_req) begin
          state_next = LOAD_BUSY;
          owner_next = gnt_idx;
          addr_next  = bus.load_addr_in[gnt_idx*ADDR_W +: ADDR_W];
        end
      end
      LOAD_BUSY: begin
        if (bus.sLoad_hit) begin
          ack[owner_reg] = 1'b1;
          rr_next        = owner_reg;
          state_next     = LOAD_IDLE;
        end
      end
      default: state_next = LOAD_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= LOAD_IDLE;
      owner_reg <= '0;
      rr_reg    <= IDX_W'(NUM_BANKS - 1);
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      rr_reg    <= rr_next;
      addr_reg  <= addr_next;
    end
  end

  assign bus.load_ack  = ack;
  assign bus.sLoad     = (state_reg == LOAD_BUSY);
  assign bus.load_addr = addr_reg;

  // ---------------- psum output FIFO ----------------
  logic [PD_W-1:0]   psum_mem [PSUM_DEPTH];
  logic [PPTR_W-1:0] pw_ptr_reg, pr_ptr_reg;
  logic [PPTR_W:0]   pcount_reg;
  logic              psum_full, psum_empty_w, psum_wr, psum_rd;
  logic [1:0]        err_reg;

  assign psum_full    = (pcount_reg == (PPTR_W+1)'(PSUM_DEPTH));
  assign psum_empty_w = (pcount_reg == '0);
  assign psum_wr      = bus.psumout_en && !psum_full;
  assign psum_rd      = (|bus.psum_ren) && !psum_empty_w;

  always_ff @(posedge CLK) begin
    if (psum_wr) psum_mem[pw_ptr_reg] <= {bus.psumout_row, bus.psumout_data};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pw_ptr_reg <= '0;
      pr_ptr_reg <= '0;
      pcount_reg <= '0;
      err_reg    <= '0;
    end else begin
      if (psum_wr) pw_ptr_reg <= pw_ptr_reg + PPTR_W'(1);
      if (psum_rd) pr_ptr_reg <= pr_ptr_reg + PPTR_W'(1);
      pcount_reg <= pcount_reg + (PPTR_W+1)'(psum_wr) - (PPTR_W+1)'(psum_rd);
      if (bus.psumout_en && psum_full) err_reg[1] <= 1'b1;
      if (instr_drop)                  err_reg[0] <= 1'b1;
    end
  end

  assign bus.psumout_ready = !psum_full;
  assign bus.psum_empty    = psum_empty_w;
  assign bus.psum_rdata    = psum_empty_w ? '0 : psum_mem[pr_ptr_reg];
  assign bus.err_overflow  = err_reg;

`ifdef SCRATCHPAD_CTRL_STATS_EN
  logic [15:0] retired_reg, busy_cnt_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      retired_reg  <= '0;
      busy_cnt_reg <= '0;
    end else begin
      if (instr_pop && retired_reg != 16'hFFFF)                busy_cnt_reg <= busy_cnt_reg;
      if (instr_pop && retired_reg != 16'hFFFF)                retired_reg  <= retired_reg + 16'd1;
      if (state_reg == LOAD_BUSY && busy_cnt_reg != 16'hFFFF)  busy_cnt_reg <= busy_cnt_reg + 16'd1;
    end
  end

  assign bus.stat_retired   = retired_reg;
  assign bus.stat_load_busy = busy_cnt_reg;
`else
  assign bus.stat_retired   = '0;
  assign bus.stat_load_busy = '0;
`endif
endmodule

// File: tb/tb_scratchpad_ctrl.sv
// Self-checking bench for scratchpad_ctrl: directed table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
`define CHK(n, a, e) check(n, 128'(a), 128'(e))

module tb_scratchpad_ctrl;
  import scratchpad_ctrl_pkg::*;

  localparam int NB = 4, IW = 40, AW = 32, PW = 64, RW = 2, MW = 6, IDP = 4, PDP = 8;
`ifdef SCRATCHPAD_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [IW-1:0] I_A = {2'b11, 1'b1, 31'd0, 6'd5};
  localparam logic [IW-1:0] I_B = {2'b01, 1'b1, 31'd0, 6'd9};
  localparam logic [IW-1:0] I_C = {2'b11, 1'b0, 31'h12345, 6'd7};

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  scratchpad_ctrl_if #(.NUM_BANKS(NB), .INSTR_W(IW), .ADDR_W(AW), .PSUM_W(PW),
                       .ROW_W(RW), .MAT_W(MW)) bus ();

  scratchpad_ctrl #(.NUM_BANKS(NB), .INSTR_W(IW), .INSTR_DEPTH(IDP), .PSUM_DEPTH(PDP),
                    .ADDR_W(AW), .PSUM_W(PW), .ROW_W(RW), .MAT_W(MW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req_v);
    end
  endtask

  task automatic drive_idle();
    bus.instr_wen = 1'b0; bus.instr_wdata = '0; bus.bank_done = '0;
    bus.load_req = '0; bus.load_addr_in = '0; bus.sLoad_hit = 1'b0;
    bus.psumout_en = 1'b0; bus.psumout_row = '0; bus.psumout_data = '0; bus.psum_ren = '0;
  endtask

  task automatic to_neg(); @(negedge CLK); endtask
  task automatic to_pos(); @(posedge CLK); #1; endtask

  task automatic do_reset();
    drive_idle();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  typedef struct {
    logic          wen;
    logic [IW-1:0] wdata;
    logic [NB-1:0] done;
    logic          e_valid;
    logic          e_new;
    logic          e_nw;
    logic [MW-1:0] e_gm;
    logic [IW-1:0] e_head;
  } vec_t;
  vec_t vt [16];

  // reference model state
  logic [IW-1:0]    m_iq [$];
  logic [RW+PW-1:0] m_pq [$];
  logic [NB-1:0]    m_acked;
  logic             m_new;
  logic [MW-1:0]    m_gm;
  logic [1:0]       m_err;
  bit               m_busy;
  int               m_owner, m_last, m_sret, m_sbusy;
  logic [AW-1:0]    m_addr;

  initial begin
    logic [NB-1:0]  lreq, ack_prev, done_v, ren_v, e_ack;
    logic [AW-1:0]  laddr [NB];
    logic [IW-1:0]  hd, wd, pushed [5];
    logic [63:0]    rnd;
    logic [RW-1:0]  row_v;
    logic [PW-1:0]  dat_v;
    logic           wen_v, hit_v, en_v, pop, pfull;
    int             sz;

    vt[0]  = '{1'b1, I_A, 4'h0, 1'b0, 1'b0, 1'b0, 6'd0, '0};
    vt[1]  = '{1'b1, I_B, 4'h0, 1'b1, 1'b1, 1'b1, 6'd0, I_A};
    vt[2]  = '{1'b0, '0,  4'h1, 1'b1, 1'b0, 1'b0, 6'd5, I_A};
    vt[3]  = '{1'b0, '0,  4'h2, 1'b1, 1'b0, 1'b0, 6'd5, I_A};
    vt[4]  = '{1'b0, '0,  4'h4, 1'b1, 1'b0, 1'b0, 6'd5, I_A};
    vt[5]  = '{1'b0, '0,  4'h8, 1'b1, 1'b0, 1'b0, 6'd5, I_A};
    vt[6]  = '{1'b0, '0,  4'h0, 1'b1, 1'b1, 1'b0, 6'd5, I_B};
    vt[7]  = '{1'b1, I_C, 4'hF, 1'b1, 1'b0, 1'b0, 6'd5, I_B};
    vt[8]  = '{1'b0, '0,  4'h0, 1'b1, 1'b1, 1'b0, 6'd5, I_C};
    vt[9]  = '{1'b0, '0,  4'hF, 1'b1, 1'b0, 1'b0, 6'd7, I_C};
    vt[10] = '{1'b0, '0,  4'h5, 1'b0, 1'b0, 1'b0, 6'd7, '0};
    vt[11] = '{1'b1, I_A, 4'h0, 1'b0, 1'b0, 1'b0, 6'd7, '0};
    vt[12] = '{1'b0, '0,  4'hA, 1'b1, 1'b1, 1'b1, 6'd7, I_A};
    vt[13] = '{1'b0, '0,  4'h0, 1'b1, 1'b0, 1'b0, 6'd5, I_A};
    vt[14] = '{1'b0, '0,  4'h5, 1'b1, 1'b0, 1'b0, 6'd5, I_A};
    vt[15] = '{1'b0, '0,  4'h0, 1'b0, 1'b0, 1'b0, 6'd5, '0};

    // reset values
    do_reset();
    to_neg();
    `CHK("rst_full", bus.instr_full, 1'b0);
    `CHK("rst_valid", bus.instr_valid, 1'b0);
    `CHK("rst_head", bus.instr_head, 40'd0);
    `CHK("rst_new", bus.instr_new, 1'b0);
    `CHK("rst_gm", bus.gemm_mat, 6'd0);
    `CHK("rst_sload", bus.sLoad, 1'b0);
    `CHK("rst_laddr", bus.load_addr, 32'd0);
    `CHK("rst_ack", bus.load_ack, 4'd0);
    `CHK("rst_ready", bus.psumout_ready, 1'b1);
    `CHK("rst_empty", bus.psum_empty, 1'b1);
    `CHK("rst_rdata", bus.psum_rdata, 66'd0);
    `CHK("rst_err", bus.err_overflow, 2'd0);
    `CHK("rst_sret", bus.stat_retired, 16'd0);
    `CHK("rst_sbusy", bus.stat_load_busy, 16'd0);
    to_pos();

    // table: instr_new / new_weight / gemm_mat / retire mask
    for (int k = 0; k < 16; k++) begin
      bus.instr_wen = vt[k].wen; bus.instr_wdata = vt[k].wdata; bus.bank_done = vt[k].done;
      to_neg();
      `CHK($sformatf("tbl%0d_valid", k), bus.instr_valid, vt[k].e_valid);
      `CHK($sformatf("tbl%0d_new", k), bus.instr_new, vt[k].e_new);
      `CHK($sformatf("tbl%0d_nw", k), bus.new_weight, vt[k].e_nw);
      `CHK($sformatf("tbl%0d_gm", k), bus.gemm_mat, vt[k].e_gm);
      `CHK($sformatf("tbl%0d_head", k), bus.instr_head, vt[k].e_head);
      to_pos();
    end

    // round-robin loads
    do_reset();
    bus.load_req = 4'b1010;
    bus.load_addr_in = {32'h300, 32'h0, 32'h100, 32'h0};
    to_neg(); `CHK("ld_lat", bus.sLoad, 1'b0); to_pos();
    to_neg(); `CHK("ld1_s", bus.sLoad, 1'b1); `CHK("ld1_a", bus.load_addr, 32'h100);
    `CHK("ld1_noack", bus.load_ack, 4'b0000); to_pos();
    bus.sLoad_hit = 1'b1;
    to_neg(); `CHK("ld1_ack", bus.load_ack, 4'b0010); to_pos();
    bus.sLoad_hit = 1'b0; bus.load_req = 4'b1000;
    to_neg(); `CHK("ld_gap1", bus.sLoad, 1'b0); to_pos();
    to_neg(); `CHK("ld2_s", bus.sLoad, 1'b1); `CHK("ld2_a", bus.load_addr, 32'h300); to_pos();
    bus.sLoad_hit = 1'b1;
    to_neg(); `CHK("ld2_ack", bus.load_ack, 4'b1000); to_pos();
    bus.sLoad_hit = 1'b0; bus.load_req = 4'b0010;
    to_neg(); `CHK("ld_gap2", bus.sLoad, 1'b0); to_pos();
    to_neg(); `CHK("ld3_a", bus.load_addr, 32'h100); to_pos();
    bus.sLoad_hit = 1'b1;
    to_neg(); `CHK("ld3_ack", bus.load_ack, 4'b0010); to_pos();
    drive_idle();
    to_neg(); `CHK("ld_sbusy", bus.stat_load_busy, STATS ? 16'd6 : 16'd0); to_pos();

    // psum overflow and ordered drain
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.psumout_en = 1'b1; bus.psumout_row = RW'(i); bus.psumout_data = 64'hA5A5_0000_0000_0000 | 64'(i);
      to_neg(); `CHK($sformatf("ps_ready%0d", i), bus.psumout_ready, i < 8); to_pos();
    end
    bus.psumout_en = 1'b0;
    to_neg(); `CHK("ps_err", bus.err_overflow, 2'b10); `CHK("ps_full", bus.psumout_ready, 1'b0); to_pos();
    for (int i = 0; i < 8; i++) begin
      bus.psum_ren = 4'(1 << (i % 4));
      to_neg(); `CHK($sformatf("ps_rd%0d", i), bus.psum_rdata, {RW'(i), 64'hA5A5_0000_0000_0000 | 64'(i)});
      to_pos();
    end
    bus.psum_ren = 4'hF;
    to_neg(); `CHK("ps_empty", bus.psum_empty, 1'b1); `CHK("ps_rd_empty", bus.psum_rdata, 66'd0); to_pos();
    bus.psum_ren = 4'h0;
    to_neg(); `CHK("ps_ready_again", bus.psumout_ready, 1'b1); `CHK("ps_empty2", bus.psum_empty, 1'b1); to_pos();

    // instruction overflow, then retire four
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pushed[i] = {2'b01, 6'(i), 32'hC0DE_0000 + 32'(i)};
      bus.instr_wen = 1'b1; bus.instr_wdata = pushed[i];
      to_neg(); `CHK($sformatf("if_full%0d", i), bus.instr_full, i >= 4); to_pos();
    end
    bus.instr_wen = 1'b0;
    to_neg(); `CHK("if_err", bus.err_overflow, 2'b01); to_pos();
    bus.bank_done = 4'hF;
    for (int i = 0; i < 4; i++) begin
      to_neg(); `CHK($sformatf("if_head%0d", i), bus.instr_head, pushed[i]); to_pos();
    end
    bus.bank_done = 4'h0;
    to_neg(); `CHK("if_drained", bus.instr_valid, 1'b0);
    `CHK("if_sret", bus.stat_retired, STATS ? 16'd4 : 16'd0); to_pos();

    // async reset while BUSY with FIFOs occupied
    do_reset();
    bus.load_req = 4'b0001; bus.load_addr_in = {96'd0, 32'h40};
    bus.instr_wen = 1'b1; bus.instr_wdata = I_A; bus.psumout_en = 1'b1;
    to_pos();
    bus.instr_wen = 1'b0; bus.psumout_en = 1'b0;
    to_neg(); `CHK("ar_pre_sload", bus.sLoad, 1'b1);
    #2 nRST = 1'b0;
    #1;
    `CHK("ar_sload", bus.sLoad, 1'b0);
    `CHK("ar_valid", bus.instr_valid, 1'b0);
    `CHK("ar_empty", bus.psum_empty, 1'b1);
    `CHK("ar_ready", bus.psumout_ready, 1'b1);
    do_reset();

    // randomized run against the reference model
    m_iq.delete(); m_pq.delete();
    m_acked = '0; m_new = 1'b0; m_gm = '0; m_err = '0;
    m_busy = 1'b0; m_owner = 0; m_last = NB - 1; m_addr = '0; m_sret = 0; m_sbusy = 0;
    lreq = '0; ack_prev = '0;
    for (int b = 0; b < NB; b++) laddr[b] = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int b = 0; b < NB; b++) begin
        if (ack_prev[b]) lreq[b] = 1'b0;
        else if (!lreq[b] && $urandom_range(0, 3) == 0) begin
          lreq[b] = 1'b1; laddr[b] = $urandom;
        end
        bus.load_addr_in[b*AW +: AW] = laddr[b];
      end
      rnd = {$urandom, $urandom};
      wen_v  = (m_iq.size() < IDP) && ($urandom_range(0, 2) == 0);
      wd     = rnd[IW-1:0];
      done_v = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      hit_v  = ($urandom_range(0, 2) == 0);
      en_v   = ($urandom_range(0, 1) == 0);
      row_v  = RW'($urandom);
      dat_v  = {$urandom, $urandom};
      ren_v  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      bus.load_req = lreq; bus.instr_wen = wen_v; bus.instr_wdata = wd; bus.bank_done = done_v;
      bus.sLoad_hit = hit_v; bus.psumout_en = en_v; bus.psumout_row = row_v;
      bus.psumout_data = dat_v; bus.psum_ren = ren_v;

      to_neg();
      sz = m_iq.size();
      hd = (sz > 0) ? m_iq[0] : '0;
      e_ack = (m_busy && hit_v) ? 4'(1 << m_owner) : 4'h0;
      `CHK("r_valid", bus.instr_valid, sz > 0);
      `CHK("r_head", bus.instr_head, hd);
      `CHK("r_full", bus.instr_full, sz == IDP);
      `CHK("r_new", bus.instr_new, m_new);
      `CHK("r_nw", bus.new_weight, m_new && hd[IW-1:IW-2] == 2'b11 && hd[IW-3]);
      `CHK("r_gm", bus.gemm_mat, m_gm);
      `CHK("r_sload", bus.sLoad, m_busy);
      `CHK("r_laddr", bus.load_addr, m_addr);
      `CHK("r_ack", bus.load_ack, e_ack);
      `CHK("r_ready", bus.psumout_ready, m_pq.size() < PDP);
      `CHK("r_empty", bus.psum_empty, m_pq.size() == 0);
      `CHK("r_rdata", bus.psum_rdata, (m_pq.size() > 0) ? m_pq[0] : '0);
      `CHK("r_err", bus.err_overflow, m_err);
      `CHK("r_sret", bus.stat_retired, STATS ? 16'(m_sret) : 16'd0);
      `CHK("r_sbusy", bus.stat_load_busy, STATS ? 16'(m_sbusy) : 16'd0);

      checks++;
      if (bus.sLoad !== m_busy) begin
        errors++;
        $display("FAIL r_sload_dir cyc %0d: got %0b expected %0b", cyc, bus.sLoad, m_busy);
      end
      checks++;
      if (bus.psum_empty !== (m_pq.size() == 0)) begin
        errors++;
        $display("FAIL r_empty_dir cyc %0d: got %0b expected %0b", cyc, bus.psum_empty, m_pq.size() == 0);
      end
      checks++;
      if (bus.instr_valid !== (sz > 0)) begin
        errors++;
        $display("FAIL r_valid_dir cyc %0d: got %0b expected %0b", cyc, bus.instr_valid, sz > 0);
      end

      // instruction queue: retire when every bank has acked the head
      pop = (sz > 0) && ((m_acked | done_v) == 4'hF);
      if (m_new && sz > 0 && hd[IW-1:IW-2] == 2'b11) m_gm = hd[MW-1:0];
      if (sz > 0) m_acked = pop ? 4'h0 : (m_acked | done_v);
      if (pop) begin
        void'(m_iq.pop_front());
        if (m_sret < 16'hFFFF) m_sret++;
      end
      if (wen_v) begin
        if (sz < IDP || pop) m_iq.push_back(wd);
        else m_err[0] = 1'b1;
      end
      m_new = (m_iq.size() > 0) && (sz == 0 || pop);

      // load arbiter: serve the first requester after the last owner
      if (m_busy) begin
        if (m_sbusy < 16'hFFFF) m_sbusy++;
        if (hit_v) begin m_last = m_owner; m_busy = 1'b0; end
      end else if (lreq != '0) begin
        for (int k = 1; k <= NB; k++) begin
          if (!m_busy && lreq[(m_last + k) % NB]) begin
            m_owner = (m_last + k) % NB; m_addr = laddr[m_owner]; m_busy = 1'b1;
          end
        end
      end

      // psum queue
      pfull = (m_pq.size() == PDP);
      if (en_v && pfull) m_err[1] = 1'b1;
      if (ren_v != '0 && m_pq.size() > 0) void'(m_pq.pop_front());
      if (en_v && !pfull) m_pq.push_back({row_v, dat_v});

      ack_prev = e_ack;
      to_pos();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
